adaptive_binarizer: RTL and testbench
=====================================

# adaptive_binarizer

Streaming grayscale-to-binary converter for the pattern-recognition path. It sits directly upstream of the binary frame-capture stage and emits 8-bit pixels that are strictly 8'd0 or 8'd255. The threshold is either a software-fixed value or the floor mean of the previous frame plus a signed offset. The mean comes from a per-frame accumulator and a sequential divider that runs in the background.

## Interface
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame
- INIT_THRESHOLD, 128, threshold used until the first mean is available
- THRESH_OFFSET, 0, signed integer added to the mean in adaptive mode (range -255..255)
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- s_valid  input  1  input pixel valid
- s_ready  output  1  input pixel accepted when s_valid && s_ready
- s_data  input  8  grayscale pixel, raster order
- m_valid  output  1  output pixel valid
- m_ready  input  1  downstream ready
- m_data  output  8  8'd255 (white) or 8'd0 (black)
- adaptive_en  input  1  1 selects the mean-based threshold; 0 selects fixed_threshold
- fixed_threshold  input  8  threshold used in fixed mode
- cur_threshold  output  8  threshold applied to the current frame
- mean_out  output  8  most recently computed frame mean
- mean_valid  output  1  one-cycle pulse when mean_out updates
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Derived constants:
  - TOTAL_PIXELS = IMG_WIDTH*IMG_HEIGHT.
  - SUM_W = 8 + $clog2(TOTAL_PIXELS).
  - TOTAL_PIXELS must be ≥ SUM_W+2; elaboration fails otherwise.
- Pixel rule: m_data = (pixel >= thr) ? 8'd255 : 8'd0.
- Pixel counter pix_cnt counts accepted input pixels from 0 to TOTAL_PIXELS-1, then wraps to 0.
- Accumulator sum (SUM_W bits) adds every accepted pixel.
- On acceptance of pixel TOTAL_PIXELS-1:
  - sum+s_data is copied into the divider dividend.
  - sum clears to 0.
  - The divider starts.
  - frame_done pulses on the next cycle.
- Divider FSM:
  - DIV_IDLE: waits for the frame-end load, then goes to DIV_RUN.
  - DIV_RUN: restoring shift-subtract by TOTAL_PIXELS, one quotient bit per cycle, SUM_W cycles, then goes to DIV_DONE.
  - DIV_DONE: writes mean_out = quotient[7:0], pulses mean_valid, sets pending_valid, then goes to DIV_IDLE.
- Threshold candidate:
  - Adaptive mode: clamp(mean_out + THRESH_OFFSET, 0, 255), using signed 11-bit arithmetic.
  - Fixed mode: fixed_threshold.
  - Before the first mean_valid, adaptive mode uses INIT_THRESHOLD.
- Frame-start latch: when the pixel with pix_cnt==0 is accepted, cur_threshold loads the candidate. That pixel is compared against the candidate combinationally (thr = pix_cnt==0 ? candidate : cur_threshold).
- pending_valid clears on that same acceptance.
- Thresholds and mode changes never take effect mid-frame.
- Accumulation and mean computation run in both modes.

## Timing
- Reset values:
  - s_ready=1, m_valid=0, m_data=0.
  - cur_threshold=INIT_THRESHOLD, mean_out=0, mean_valid=0, frame_done=0.
  - pix_cnt=0, sum=0, divider state DIV_IDLE, pending_valid=0.
- Data path is one register stage: the output appears 1 cycle after acceptance. Full throughput is one pixel per cycle.
- Handshake:
  - s_ready = !m_valid || m_ready (combinational).
  - m_valid/m_data hold stable while m_valid && !m_ready.
  - Simultaneous output consumption and new input acceptance in one cycle is required and is lossless.
- Mean latency: mean_valid asserts SUM_W+1 cycles after the cycle in which the last pixel is accepted. It is applied at the next frame start.
- If the next frame starts before mean_valid, that frame uses the old candidate. The new mean applies to the frame after it.
- The divider always finishes before the following frame end; this is guaranteed by the TOTAL_PIXELS constraint.
- Reset mid-frame discards the partial sum, pixel count, in-flight output pixel and any divider run. The next accepted pixel is treated as pixel 0.

## Structure
- Shared package binarizer_pkg holds:
  - the divider state typedef (DIV_IDLE, DIV_RUN, DIV_DONE);
  - WHITE=8'd255 and BLACK=8'd0;
  - a SUM_W helper function.
- One sub-module: seq_divider. It is a parameterised unsigned restoring divider with start/done, width SUM_W, and a constant divisor port. The accumulator, counter, threshold logic and output register stay in the top module.

## Test plan
Use IMG_WIDTH=4, IMG_HEIGHT=4 unless stated.
- Fixed mode, fixed_threshold=128, inputs 127,128,255,0 → outputs 0,255,255,0, each 1 cycle after acceptance.
- Adaptive mode, frame 1 all pixels 100 → mean_out=100 with mean_valid SUM_W+1 cycles after pixel 15. Frame 2 inputs 99,100 → outputs 0,255 (frame 1 used INIT_THRESHOLD=128).
- THRESH_OFFSET=+200, frame mean 100 → cur_threshold=255, so 254→0 and 255→255. THRESH_OFFSET=-200 → cur_threshold=0, all pixels → 255.
- Random m_ready (about 50% duty) with continuous s_valid over 3 frames → no loss or duplication; output count is 48; m_data is stable whenever it is stalled.
- Change fixed_threshold from 128 to 50 at pixel 7 → pixels 8–15 still use 128; the next frame uses 50.
- Assert rst_n low at pixel 9 of a frame → all outputs return to reset values. The following 16-pixel constant-200 frame yields mean_out=200, with no contribution from pre-reset pixels.

Source files
------------

// File: rtl/binarizer_pkg.sv
// Shared types and constants for the adaptive binarizer and its mean divider.
package binarizer_pkg;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

  localparam logic [7:0] WHITE = 8'd255;
  localparam logic [7:0] BLACK = 8'd0;

  // Accumulator width: enough for a full frame of 8-bit pixels.
  function automatic int sum_width(input int total_pixels);
    return 8 + $clog2(total_pixels);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, W cycles per run.
// done pulses with quotient valid W+1 cycles after start; quotient holds until the next run.
module seq_divider
  import binarizer_pkg::*;
#(
  parameter int W   = 12,
  parameter int Q_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   dividend,
  input  logic [W-1:0]   divisor,
  output logic           done,
  output logic [Q_W-1:0] quotient
);

  localparam int CNT_W = $clog2(W + 1);

  div_state_t       state;
  logic [W-1:0]     q_work;
  logic [W-1:0]     rem;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       rem_sh;
  logic             fits;

  assign rem_sh = {rem, q_work[W-1]};
  assign fits   = rem_sh >= {1'b0, divisor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DIV_IDLE;
      q_work   <= '0;
      rem      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start) begin
            q_work <= dividend;
            rem    <= '0;
            cnt    <= '0;
            state  <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          q_work <= {q_work[W-2:0], fits};
          rem    <= fits ? W'(rem_sh - {1'b0, divisor}) : rem_sh[W-1:0];
          cnt    <= cnt + 1'b1;
          // Final bit: publish the result as we enter DIV_DONE.
          if (cnt == CNT_W'(W - 1)) begin
            quotient <= {q_work[Q_W-2:0], fits};
            done     <= 1'b1;
            state    <= DIV_DONE;
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/adaptive_binarizer.sv
// Streaming grayscale-to-binary converter with fixed or previous-frame-mean threshold.
// One register stage; s_ready = !m_valid || m_ready, full throughput, output held while stalled.
module adaptive_binarizer
  import binarizer_pkg::*;
#(
  parameter int IMG_WIDTH      = 640,
  parameter int IMG_HEIGHT     = 480,
  parameter int INIT_THRESHOLD = 128,
  parameter int THRESH_OFFSET  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  input  logic       adaptive_en,
  input  logic [7:0] fixed_threshold,
  output logic [7:0] cur_threshold,
  output logic [7:0] mean_out,
  output logic       mean_valid,
  output logic       frame_done
);

  localparam int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int SUM_W        = sum_width(TOTAL_PIXELS);
  localparam int CNT_W        = $clog2(TOTAL_PIXELS);
  localparam logic [SUM_W-1:0]  DIVISOR  = SUM_W'(TOTAL_PIXELS);
  localparam logic [7:0]        INIT_THR = 8'(INIT_THRESHOLD);
  localparam logic signed [10:0] OFFSET  = 11'(THRESH_OFFSET);

  // The divider must finish before the next frame can possibly end.
  if (TOTAL_PIXELS < SUM_W + 2) begin : g_bad_size
    $error("adaptive_binarizer: frame too small for the mean divider");
  end

  logic [CNT_W-1:0]  pix_cnt;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  dividend;
  logic              accept, first_pix, last_pix, frame_end;
  logic              pending_valid, have_mean;
  logic signed [10:0] adj;
  logic [7:0]        adapt_thr, candidate, thr;

  assign s_ready   = !m_valid || m_ready;
  assign accept    = s_valid && s_ready;
  assign first_pix = pix_cnt == '0;
  assign last_pix  = pix_cnt == CNT_W'(TOTAL_PIXELS - 1);
  assign frame_end = accept && last_pix;
  assign dividend  = sum + {{(SUM_W-8){1'b0}}, s_data};
  assign adj       = $signed({3'b000, mean_out}) + OFFSET;

  always_comb begin
    adapt_thr = INIT_THR;
    if (have_mean || pending_valid || mean_valid) begin
      if (adj[10])                adapt_thr = 8'd0;
      else if (adj > 11'sd255)    adapt_thr = 8'd255;
      else                        adapt_thr = adj[7:0];
    end
    candidate = adaptive_en ? adapt_thr : fixed_threshold;
    // Pixel 0 sees the threshold it is latching in the same cycle.
    thr = first_pix ? candidate : cur_threshold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt       <= '0;
      sum           <= '0;
      cur_threshold <= INIT_THR;
      pending_valid <= 1'b0;
      have_mean     <= 1'b0;
      frame_done    <= 1'b0;
      m_valid       <= 1'b0;
      m_data        <= BLACK;
    end else begin
      frame_done <= frame_end;
      if (accept) begin
        pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
        sum     <= last_pix ? '0 : dividend;
        m_valid <= 1'b1;
        m_data  <= (s_data >= thr) ? WHITE : BLACK;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (accept && first_pix) begin
        cur_threshold <= candidate;
        pending_valid <= 1'b0;
        have_mean     <= have_mean || pending_valid || mean_valid;
      end else if (mean_valid) begin
        pending_valid <= 1'b1;
      end
    end
  end

  seq_divider #(.W(SUM_W), .Q_W(8)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (frame_end),
    .dividend (dividend),
    .divisor  (DIVISOR),
    .done     (mean_valid),
    .quotient (mean_out)
  );

endmodule

// File: tb/tb_adaptive_binarizer.sv
// Three 4x4 binarizers (offsets 0, +200, -200) on shared stimulus, checked by a queue scoreboard.
module tb_adaptive_binarizer;

  localparam int NPIX  = 16;
  localparam int SUM_W = 8 + $clog2(NPIX);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       m_ready;
  logic       adaptive_en;
  logic [7:0] fixed_threshold;
  logic [2:0] s_ready_v, m_valid_v, mean_valid_v, frame_done_v;
  logic [7:0] m_data_v [3];
  logic [7:0] cur_thr_v [3];
  logic [7:0] mean_out_v [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adaptive_binarizer #(
      .IMG_WIDTH(4), .IMG_HEIGHT(4), .INIT_THRESHOLD(128),
      .THRESH_OFFSET((g == 0) ? 0 : (g == 1) ? 200 : -200)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready_v[g]), .s_data(s_data),
      .m_valid(m_valid_v[g]), .m_ready(m_ready), .m_data(m_data_v[g]),
      .adaptive_en(adaptive_en), .fixed_threshold(fixed_threshold),
      .cur_threshold(cur_thr_v[g]), .mean_out(mean_out_v[g]),
      .mean_valid(mean_valid_v[g]), .frame_done(frame_done_v[g])
    );
  end

  typedef struct packed {
    logic [31:0]     acc;
    logic [2:0][7:0] d;
    logic [2:0][7:0] t;
  } exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  val;
  } ev_t;

  exp_t sb [$];
  ev_t  mean_q [$];
  ev_t  fd_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_push   = 0;
  int n_disc   = 0;
  int n_out    = 0;
  bit rand_ready = 1'b0;

  // Reference model state
  int pcnt = 0, fsum = 0;
  int cur_mean = 0;
  bit have_m = 0;
  bit pend_v = 0;
  int pend_cyc = 0, pend_val = 0;
  int frame_thr [3];
  int offs [3] = '{0, 200, -200};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int clamp255(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  task automatic promote();
    if (pend_v && cyc >= pend_cyc) begin
      cur_mean = pend_val;
      have_m   = 1;
      pend_v   = 0;
    end
  endtask

  // Called in the cycle where the pixel is accepted.
  task automatic model_accept(input int pix);
    exp_t e;
    if (pcnt == 0) begin
      promote();
      for (int g = 0; g < 3; g++)
        frame_thr[g] = adaptive_en ? (have_m ? clamp255(cur_mean + offs[g]) : 128)
                                   : int'(fixed_threshold);
    end
    e.acc = 32'(cyc);
    for (int g = 0; g < 3; g++) begin
      e.d[g] = (pix >= frame_thr[g]) ? 8'd255 : 8'd0;
      e.t[g] = 8'(frame_thr[g]);
    end
    sb.push_back(e);
    n_push++;
    fsum += pix;
    pcnt++;
    if (pcnt == NPIX) begin
      promote();
      pend_v   = 1;
      pend_cyc = cyc + SUM_W + 1;
      pend_val = fsum / NPIX;
      mean_q.push_back('{cyc: 32'(pend_cyc), val: 8'(pend_val)});
      fd_q.push_back('{cyc: 32'(cyc + 1), val: 8'd0});
      pcnt = 0;
      fsum = 0;
    end
  endtask

  task automatic model_reset();
    n_disc += sb.size();
    sb.delete();
    mean_q.delete();
    fd_q.delete();
    pcnt = 0; fsum = 0; cur_mean = 0; have_m = 0; pend_v = 0;
  endtask

  task automatic check_reset_state();
    for (int g = 0; g < 3; g++) begin
      chk("rst_s_ready", s_ready_v[g], 1);
      chk("rst_m_valid", m_valid_v[g], 0);
      chk("rst_m_data", m_data_v[g], 0);
      chk("rst_cur_threshold", cur_thr_v[g], 128);
      chk("rst_mean_out", mean_out_v[g], 0);
      chk("rst_mean_valid", mean_valid_v[g], 0);
      chk("rst_frame_done", frame_done_v[g], 0);
    end
  endtask

  task automatic send(input int pix);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = 8'(pix);
    @(negedge clk);
    while (!s_ready_v[0] && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!s_ready_v[0]) begin
      chk("accept_timeout", 0, 1);
      s_valid = 1'b0;
    end else begin
      model_accept(pix);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    model_reset();
    #2 check_reset_state();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: latency, stall stability, data and threshold per instance.
  bit         fresh = 1;
  logic [7:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      fresh = 1;
    end else begin
      if (m_valid_v[0]) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          if (fresh) chk("latency", cyc, int'(sb[0].acc) + 1);
          else       chk("stall_hold", m_data_v[0], held);
          if (m_ready) begin
            for (int g = 0; g < 3; g++) begin
              chk("m_valid", m_valid_v[g], 1);
              chk("m_data", m_data_v[g], sb[0].d[g]);
              chk("cur_threshold", cur_thr_v[g], sb[0].t[g]);
            end
            void'(sb.pop_front());
            n_out++;
          end
        end
        fresh = m_ready;
        held  = m_data_v[0];
      end else begin
        fresh = 1;
      end
      begin
        bit exp_mv, exp_fd;
        exp_mv = mean_q.size() > 0 && int'(mean_q[0].cyc) == cyc;
        exp_fd = fd_q.size() > 0 && int'(fd_q[0].cyc) == cyc;
        for (int g = 0; g < 3; g++) begin
          if (exp_mv || mean_valid_v[g]) chk("mean_valid", mean_valid_v[g], exp_mv);
          if (exp_mv) chk("mean_out", mean_out_v[g], mean_q[0].val);
          if (exp_fd || frame_done_v[g]) chk("frame_done", frame_done_v[g], exp_fd);
        end
        if (exp_mv) void'(mean_q.pop_front());
        if (exp_fd) void'(fd_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int base, guard;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    adaptive_en = 1'b0; fixed_threshold = 8'd128;
    #12 check_reset_state();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed mode, threshold edges, then a mid-frame threshold change.
    send(127); send(128); send(255); send(0);
    for (int i = 4; i < 8; i++) send($urandom_range(0, 255));
    fixed_threshold = 8'd50;
    for (int i = 8; i < 16; i++) send($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) send($urandom_range(0, 255));

    // Reset during pixel 9, then a clean constant frame.
    for (int i = 0; i < 9; i++) send($urandom_range(0, 255));
    do_reset();
    for (int i = 0; i < 16; i++) send(200);
    idle(20);

    // Adaptive mode from a fresh reset.
    do_reset();
    adaptive_en = 1'b1;
    for (int i = 0; i < 16; i++) send(100);
    idle(20);
    send(99); send(100); send(254); send(255);
    for (int i = 4; i < 16; i++) send($urandom_range(0, 255));
    idle(20);

    // Random downstream backpressure, continuous input over three frames.
    base = n_out;
    rand_ready = 1'b1;
    for (int i = 0; i < 48; i++) send($urandom_range(0, 255));
    s_valid = 1'b0;
    rand_ready = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    #1 chk("backpressure_out_count", n_out - base, 48);
    idle(20);

    chk("scoreboard_empty", sb.size(), 0);
    chk("mean_events_seen", mean_q.size(), 0);
    chk("total_out_count", n_out, n_push - n_disc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
